spi_slave_port: RTL
===================

# spi_slave_port

SPI slave front end that streams the capture result bytes to the host MCU. It sits directly downstream of the `spi_memory` byte register file. It drives that block's `reset_addr` and `incr` controls and shifts its `out_byte` onto MISO, MSB first, in SPI mode 0. It also deserialises MOSI into bytes for a future command path. Everything runs in the `clk` domain: SCK, SS_N and MOSI are oversampled through synchronisers.

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of each input synchroniser (≥2).
- `clk`  in  1: system clock; all logic on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `sck`  in  1: raw SPI clock from master (asynchronous).
- `ss_n`  in  1: raw slave select, active low (asynchronous).
- `mosi`  in  1: raw master-out data (asynchronous).
- `miso`  out  1: slave-out data. Driven 0 when not selected.
- `byte_in`  in  8: current byte from the memory (`out_byte`).
- `reset_addr`  out  1: high whenever the port is idle. Holds the memory address at 0.
- `incr`  out  1: one-cycle pulse per completed byte. Advances the memory address.
- `rx_data`  out  8: last fully received MOSI byte.
- `rx_valid`  out  1: one-cycle pulse when `rx_data` updates.
- `active`  out  1: high while in SHIFT state.

## Operation
- Synchronisers: SCK, SS_N and MOSI each pass through `SYNC_STAGES` flops.
- Edge detectors on synced SCK produce `sck_rise` and `sck_fall` strobes. Each strobe is one cycle wide.
- FSM states: IDLE, SHIFT.
- IDLE behaviour:
  - `reset_addr`=1, `active`=0, `miso`=0, bit counter=0, reload flag=0.
  - When synced `ss_n`=0: load `tx_shift <= byte_in` (address 0 is already valid) and go to SHIFT.
- SHIFT, `miso = tx_shift[7]`, `reset_addr`=0:
  - On `sck_rise`: shift `rx_shift <= {rx_shift[6:0], mosi_sync}` and increment the 3-bit counter.
  - When the counter was 7 on that rise:
    - Counter wraps to 0.
    - Next cycle: `incr`=1, `rx_data` updated, `rx_valid`=1, reload flag set.
  - On `sck_fall`:
    - If the reload flag is set: `tx_shift <= byte_in` and clear the flag.
    - Otherwise: `tx_shift <= tx_shift << 1`.
  - Synced `ss_n`=1 takes priority over edges in the same cycle. Action: go to IDLE, discard the partial byte, no `incr` or `rx_valid` for it.
- The memory wraps at 8 bytes. A 9th byte in one transaction therefore repeats byte 0 (F low byte). This is intended.
- `rst` mid-transfer behaviour:
  - Next cycle the FSM is in IDLE.
  - Outputs return to their reset values.
  - The pending `incr` is dropped.

## Timing
- Reset values:
  - `miso`=0, `reset_addr`=1, `incr`=0, `rx_data`=0x00, `rx_valid`=0, `active`=0.
  - Both shift registers 0, counter 0.
- Pin-to-strobe latency: `SYNC_STAGES`+1 clk cycles.
- Byte-boundary sequence, with the 8th `sck_rise` seen in cycle T:
  - `incr`=1 in T+1.
  - Memory `addr` updates at T+2.
  - `byte_in` is valid from T+2.
- SCK requirement: high and low phases each ≥4 clk cycles, so `sck_fall` arrives at ≥T+4 and the reload sees the new byte. Max SCK = clk/8.
- SS_N fall to first SCK rise at master pins: ≥`SYNC_STAGES`+3 clk cycles.
- SS_N high time between transactions: ≥`SYNC_STAGES`+3 clk cycles, so the memory address is reset.
- `incr` pulses are always separated by ≥7 low cycles. This satisfies the memory's edge detector.

## Structure
- Shared package `spi_pkg`, containing:
  - State enum `spi_state_t` {IDLE, SHIFT}.
  - `SPI_BYTE_BITS`=8.
  - `SPI_MIN_HALF_PERIOD`=4.
- Sub-module `sync_edge`: N-stage synchroniser with registered rise/fall strobes.
  - Instantiated for SCK and SS_N.
  - MOSI uses the synchroniser only.

## Test plan
- Single byte: `byte_in`=0xA5, one 8-bit mode-0 transfer at clk/8 -> MISO bits 1,0,1,0,0,1,0,1; exactly one `incr`; `reset_addr` high again after SS_N rises.
- Full readout: bench models `spi_memory` with F=0x1234, C=0x5678, L=0x9ABC, R=0xDEF0; 8 bytes -> MISO stream 34 12 78 56 BC 9A F0 DE; 8 `incr` pulses.
- Wrap: same as full readout with 9 bytes -> 9th byte is 0x34.
- Receive: master sends 0x3C on MOSI -> `rx_data`=0x3C with a single-cycle `rx_valid`, one cycle after the 8th rise.
- Abort: SS_N deasserted after 3 bits -> no `incr`, no `rx_valid`, `reset_addr`=1 within `SYNC_STAGES`+2 cycles; next transaction starts from byte 0.
- Reset mid-byte: `rst` pulsed after 5 bits -> all outputs at reset values the next cycle; next transfer returns byte 0 correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave read-out port.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  localparam int SPI_BYTE_BITS       = 8;
  localparam int SPI_MIN_HALF_PERIOD = 4;

endpackage

// File: rtl/spi_slave_port_sync_edge.sv
// N-stage input synchroniser with registered one-cycle rise/fall strobes.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_in};
    prev_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~prev_q;
    fall_d = ~sync_q[STAGES-1] & prev_q;
  end

  // Reset to the line's idle level so no false edge appears after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave: streams memory bytes onto MISO, deserialises MOSI.
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ss_n,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] byte_in,
  output logic       reset_addr,
  output logic       incr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       active
);

  localparam int CNT_W = $clog2(SPI_BYTE_BITS);
  localparam logic [CNT_W-1:0] BIT_CNT_LAST = CNT_W'(SPI_BYTE_BITS - 1);

  logic sck_rise, sck_fall, sck_level;
  logic ss_sync, ss_rise, ss_fall;
  logic sync_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .d_in(sck),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .d_in(ss_n),
    .level(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  assign sync_unused = sck_level ^ ss_rise ^ ss_fall;

  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_sync;

  spi_state_t         state_q, state_d;
  logic [7:0]         tx_shift_q, tx_shift_d;
  logic [7:0]         rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               reload_q, reload_d;
  logic               incr_q, incr_d;
  logic               rx_valid_q, rx_valid_d;
  logic [7:0]         rx_data_q, rx_data_d;

  assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];

  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    state_d     = state_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    bit_cnt_d   = bit_cnt_q;
    reload_d    = reload_q;
    incr_d      = 1'b0;
    rx_valid_d  = 1'b0;
    rx_data_d   = rx_data_q;
    miso        = 1'b0;
    reset_addr  = 1'b1;
    active      = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d  = '0;
        reload_d   = 1'b0;
        rx_shift_d = '0;
        if (!ss_sync) begin
          tx_shift_d = byte_in;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        miso       = tx_shift_q[7];
        reset_addr = 1'b0;
        active     = 1'b1;
        // Deselect wins over any edge in the same cycle; partial byte is dropped.
        if (ss_sync) begin
          state_d = IDLE;
        end else begin
          if (sck_rise) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_sync};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == BIT_CNT_LAST) begin
              incr_d     = 1'b1;
              rx_valid_d = 1'b1;
              rx_data_d  = rx_shift_d;
              reload_d   = 1'b1;
            end
          end
          // The memory's next byte is valid well before the following fall.
          if (sck_fall) begin
            if (reload_q) begin
              tx_shift_d = byte_in;
              reload_d   = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      reload_q    <= 1'b0;
      incr_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      bit_cnt_q   <= bit_cnt_d;
      reload_q    <= reload_d;
      incr_q      <= incr_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
    end
  end

  assign incr     = incr_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule
